// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped, write-back data cache.
package dcache_pkg;

   localparam int TAG_W      = 23;
   localparam int IDX_W      = 4;
   localparam int LINE_W     = 256;
   localparam int WORD_SEL_W = 3;
   localparam int NUM_LINES  = 16;
   localparam int WORD_W     = 32;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_ALLOCATE  = 2'd2,
      ST_REFILL    = 2'd3
   } dcache_state_e;

   // Returns the line with one 32-bit word replaced; word 0 sits in bits [31:0].
   function automatic logic [LINE_W-1:0] line_merge(input logic [LINE_W-1:0]     line,
                                                    input logic [WORD_SEL_W-1:0] sel,
                                                    input logic [WORD_W-1:0]     word);
      logic [LINE_W-1:0] merged;
      merged = line;
      merged[WORD_W*sel +: WORD_W] = word;
      return merged;
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: one asynchronous read port, one write port.
module dcache_sram
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_data,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic              wr_dirty,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_data
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [LINE_W-1:0]    data_mem [NUM_LINES];

   // Only the status bits are reset; tag and data are don't-care until valid.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (we) begin
         valid_q[wr_idx] <= 1'b1;
         dirty_q[wr_idx] <= wr_dirty;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller: FSM, hit
// detection and CPU/memory datapath around the dcache_sram storage.
module dcache_controller
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_write_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);

   localparam logic [1:0] IDLE      = ST_IDLE;
   localparam logic [1:0] WRITEBACK = ST_WRITEBACK;
   localparam logic [1:0] ALLOCATE  = ST_ALLOCATE;
   localparam logic [1:0] REFILL    = ST_REFILL;

   logic [1:0]            state_q;
   logic [1:0]            state_d;
   logic [TAG_W-1:0]      cpu_tag;
   logic [IDX_W-1:0]      cpu_idx;
   logic [WORD_SEL_W-1:0] cpu_wsel;
   logic [1:0]            unused_addr_bits;
   logic                  rd_valid, rd_dirty;
   logic [TAG_W-1:0]      rd_tag;
   logic [LINE_W-1:0]     rd_data;
   logic                  hit, in_idle, load_hit, store_hit, miss;
   logic                  we, wr_dirty;
   logic [LINE_W-1:0]     wr_data;

   assign cpu_tag          = cpu_addr_i[31:9];
   assign cpu_idx          = cpu_addr_i[8:5];
   assign cpu_wsel         = cpu_addr_i[4:2];
   assign unused_addr_bits = cpu_addr_i[1:0];

   assign hit       = rd_valid && (rd_tag == cpu_tag);
   assign in_idle   = (state_q == IDLE);
   assign load_hit  = rst_i && in_idle && cpu_req_i && !cpu_write_i && hit;
   assign store_hit = in_idle && cpu_req_i && cpu_write_i && hit;
   assign miss      = in_idle && cpu_req_i && !hit;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (miss) state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
         WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
         ALLOCATE:  if (mem_ack_i) state_d = REFILL;
         default:   state_d = IDLE;
      endcase
   end

   // Memory handshake: mem_enable_o/mem_write_o/mem_addr_o are held from state
   // until the single-cycle mem_ack_i; the FSM leaves that state on the ack edge,
   // so enable drops in the following cycle. Ack outside WRITEBACK/ALLOCATE is ignored.
   assign mem_enable_o = (state_q == WRITEBACK) || (state_q == ALLOCATE);
   assign mem_write_o  = (state_q == WRITEBACK);
   assign mem_addr_o   = (state_q == WRITEBACK) ? {rd_tag, cpu_idx, 5'b0} :
                         (state_q == ALLOCATE)  ? {cpu_tag, cpu_idx, 5'b0} : 32'd0;
   assign mem_data_o   = (state_q == WRITEBACK) ? rd_data : '0;

   assign cpu_stall_o = rst_i && (miss || !in_idle);
   assign cpu_data_o  = load_hit ? rd_data[WORD_W*cpu_wsel +: WORD_W] : 32'd0;

   assign we       = store_hit || ((state_q == ALLOCATE) && mem_ack_i);
   assign wr_dirty = store_hit;
   assign wr_data  = store_hit ? line_merge(rd_data, cpu_wsel, cpu_data_i) : mem_data_i;

   dcache_sram u_sram (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rd_idx   (cpu_idx),
      .rd_valid (rd_valid),
      .rd_dirty (rd_dirty),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .we       (we),
      .wr_idx   (cpu_idx),
      .wr_dirty (wr_dirty),
      .wr_tag   (cpu_tag),
      .wr_data  (wr_data)
   );

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The module SHALL have these ports, one per line (name  direction  width  meaning):
  clk_i  in  1  clock; the only clock; all state changes on its rising edge
  rst_i  in  1  asynchronous, active-low reset
  cpu_req_i  in  1  CPU data access valid (MemRead or MemWrite)
  cpu_write_i  in  1  1 = store, 0 = load
  cpu_addr_i  in  32  byte address; tag = [31:9], index = [8:5], word = [4:2], [1:0] ignored
  cpu_data_i  in  32  store data
  cpu_data_o  out  32  load data
  cpu_stall_o  out  1  freeze the pipeline
  mem_enable_o  out  1  memory request
  mem_write_o  out  1  1 = line write-back, 0 = line fetch
  mem_addr_o  out  32  line address, bits [4:0] = 0
  mem_data_o  out  256  write-back line
  mem_data_i  in  256  fetched line
  mem_ack_i  in  1  one-cycle completion pulse
REQ-002 The cache SHALL be direct-mapped, write-back and write-allocate, with 16 lines of 32 bytes each.

Function
REQ-003 The FSM SHALL have the states IDLE, WRITEBACK, ALLOCATE and REFILL.
REQ-004 Hit condition: valid[index] AND tag[index] == cpu_addr_i[31:9].
REQ-005 In IDLE, on cpu_req_i with a hit, cpu_stall_o SHALL be 0 in the same cycle (combinational, zero extra latency).
REQ-006 On a load hit, cpu_data_o SHALL be the selected word of the line, combinationally; cpu_data_o SHALL be 0 when there is no load hit.
REQ-007 On a store hit, at the clock edge, the selected word SHALL be replaced by cpu_data_i and dirty[index] SHALL be set to 1.
REQ-008 In IDLE, on cpu_req_i with a miss, cpu_stall_o SHALL be 1 in the same cycle.
REQ-009 On an IDLE miss, the next state SHALL be WRITEBACK if the victim line is valid and dirty, otherwise ALLOCATE.
REQ-010 In WRITEBACK, mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0} and mem_data_o=victim line; on mem_ack_i the FSM SHALL go to ALLOCATE.
REQ-011 In ALLOCATE, mem_enable_o=1, mem_write_o=0 and mem_addr_o={cpu tag, index, 5'b0}.
REQ-012 On mem_ack_i in ALLOCATE: line=mem_data_i, tag written, valid=1, dirty=0, and the FSM SHALL go to REFILL.
REQ-013 REFILL SHALL last exactly 1 cycle and then go to IDLE; the held request then hits per REQ-005 to REQ-007.
REQ-014 cpu_stall_o SHALL be 1 in WRITEBACK, ALLOCATE and REFILL.
REQ-015 mem_enable_o, mem_write_o and mem_addr_o SHALL be Moore outputs decoded from state and held stable until mem_ack_i; mem_enable_o SHALL drop in the cycle after the ack.
REQ-016 mem_ack_i SHALL be ignored in IDLE and REFILL.
REQ-017 In IDLE with cpu_req_i=0, there SHALL be no state change, no array write, and cpu_stall_o=0.
REQ-018 The CPU SHALL hold cpu_req_i, cpu_write_i, cpu_addr_i and cpu_data_i stable while cpu_stall_o=1; the controller SHALL sample them only in IDLE and in the post-REFILL hit.
REQ-019 Outside WRITEBACK, mem_data_o SHALL be 0.

Reset
REQ-020 rst_i low SHALL asynchronously force: state=IDLE, all valid and dirty bits = 0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, cpu_stall_o=0, cpu_data_o=0.
REQ-021 Reset mid-operation (WRITEBACK or ALLOCATE) SHALL abort the transaction immediately; no line SHALL be written.
REQ-022 Tag and data contents need not be reset.

Structure
REQ-023 The shared package dcache_pkg SHALL hold: the state enum, TAG_W=23, IDX_W=4, LINE_W=256, WORD_SEL_W=3, NUM_LINES=16.
REQ-024 Tag/valid/dirty/data storage SHALL be one sub-module, dcache_sram, with 1 read port and 1 write port; the FSM and hit logic SHALL reside in dcache_controller.

Verification
REQ-025 The bench SHALL cover these scenarios (stimulus -> required response):
  - Reset, then load 0x0000_0040 -> ALLOCATE with mem_addr_o=0x40; ack 3 cycles later with word0=0x1111_1111 -> REFILL, then cpu_data_o=0x1111_1111 with stall low; stall high for exactly 5 cycles.
  - Store 0xDEAD_BEEF to 0x44 after the previous scenario -> no stall; next load from 0x44 returns 0xDEAD_BEEF; dirty[2]=1.
  - Load 0x0000_0240 (index 2, tag 1) -> WRITEBACK with mem_addr_o=0x40 and mem_data_o[63:32]=0xDEAD_BEEF, then ALLOCATE with mem_addr_o=0x240, then the hit.
  - rst_i low during ALLOCATE -> mem_enable_o=0 and stall=0 in the same cycle; reload of 0x40 misses.
  - mem_ack_i pulsed in IDLE with cpu_req_i=0 -> no state change, mem_enable_o stays 0.
  - Load 0x40 then 0x40 again (clean) -> second access hits; the miss goes to ALLOCATE directly with no WRITEBACK.
